// File: rtl/aud_rmm_arb.sv
// aud_rmm_arb: two-port round-robin arbiter and command sequencer for the aud_rmm engine.
// Grants one read/write transaction at a time, drives the aud_rmm command interface,
// and returns read data / error to the winning requester.
// Optional build macro: AUD_ARB_TIMEOUT_EN adds a WAIT watchdog, the rmm_rst_req pulse
// and the sticky timeout_seen output.
module aud_rmm_arb #(
    parameter int unsigned CMD_CYCLES     = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        aud_ck,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_write,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic [1:0]  req0_size,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_write,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic [1:0]  req1_size,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    output logic        rsp0_err,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic        rsp1_err,
    output logic [31:0] rmm_addr,
    output logic [31:0] rmm_wdata,
    output logic        rmm_data_oe,
    input  logic [31:0] rmm_rdata,
    output logic [1:0]  rmm_size,
    output logic        rmm_we,
    output logic        rmm_re,
    input  logic        rmm_done,
    input  logic        rmm_err,
    output logic        rmm_rst_req,
`ifdef AUD_ARB_TIMEOUT_EN
    output logic        timeout_seen,
`endif
    output logic        busy
);

    if (CMD_CYCLES < 1 || CMD_CYCLES > 15) begin : g_bad_cmd_cycles
        $error("aud_rmm_arb: CMD_CYCLES must be in 1..15");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout_cycles
        $error("aud_rmm_arb: TIMEOUT_CYCLES must be in 1..65535");
    end

    localparam logic [3:0] CmdLast = 4'(CMD_CYCLES);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e      state_q;
    logic        last_grant_q;
    logic        gnt_q;
    logic        write_q;
    logic [3:0]  cmd_cnt_q;

    logic        handshake;
    logic        sel_write;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [1:0]  sel_size;

    logic        rsp_set;
    logic        rsp_port;
    logic        rsp_err_n;
    logic [31:0] rsp_rdata_n;

`ifdef AUD_ARB_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt_q;
`else
    assign rmm_rst_req = 1'b0;
`endif

    // Round-robin arbitration: on contention the port that did not win last time is ready.
    // Gated by rst so that ready reads 0 while reset is held.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state_q == StIdle && !rst) begin
            if (req0_valid && (!req1_valid || last_grant_q)) begin
                req0_ready = 1'b1;
            end else if (req1_valid) begin
                req1_ready = 1'b1;
            end
        end
    end

    assign handshake = req0_ready | req1_ready;

    // Select the accepted port's request fields.
    always_comb begin
        if (req1_ready) begin
            sel_write = req1_write;
            sel_addr  = req1_addr;
            sel_wdata = req1_wdata;
            sel_size  = req1_size;
        end else begin
            sel_write = req0_write;
            sel_addr  = req0_addr;
            sel_wdata = req0_wdata;
            sel_size  = req0_size;
        end
    end

    // Decide when a response is produced and what it carries.
    always_comb begin
        rsp_set     = 1'b0;
        rsp_port    = gnt_q;
        rsp_err_n   = 1'b0;
        rsp_rdata_n = '0;
        case (state_q)
            StIdle: begin
                // Illegal size is answered directly without touching aud_rmm.
                if (handshake && sel_size == 2'd3) begin
                    rsp_set   = 1'b1;
                    rsp_port  = req1_ready;
                    rsp_err_n = 1'b1;
                end
            end
            StWait: begin
`ifdef AUD_ARB_TIMEOUT_EN
                if (rmm_rst_req) begin
                    rsp_set   = 1'b1;
                    rsp_err_n = 1'b1;
                end else
`endif
                if (rmm_done || rmm_err) begin
                    rsp_set     = 1'b1;
                    rsp_err_n   = rmm_err;
                    rsp_rdata_n = write_q ? 32'h0 : rmm_rdata;
                end
            end
            default: ;
        endcase
    end

    // Per-port response registers; rdata/err hold until the next response to that port.
    always_ff @(posedge aud_ck or posedge rst) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
            rsp1_err   <= 1'b0;
        end else begin
            rsp0_valid <= rsp_set & ~rsp_port;
            rsp1_valid <= rsp_set & rsp_port;
            if (rsp_set && !rsp_port) begin
                rsp0_rdata <= rsp_rdata_n;
                rsp0_err   <= rsp_err_n;
            end
            if (rsp_set && rsp_port) begin
                rsp1_rdata <= rsp_rdata_n;
                rsp1_err   <= rsp_err_n;
            end
        end
    end

    // Transaction sequencer with registered aud_rmm command outputs.
    always_ff @(posedge aud_ck or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            write_q      <= 1'b0;
            cmd_cnt_q    <= '0;
            rmm_addr     <= '0;
            rmm_wdata    <= '0;
            rmm_size     <= '0;
            rmm_we       <= 1'b0;
            rmm_re       <= 1'b0;
            rmm_data_oe  <= 1'b0;
            busy         <= 1'b0;
`ifdef AUD_ARB_TIMEOUT_EN
            wait_cnt_q   <= '0;
            rmm_rst_req  <= 1'b0;
            timeout_seen <= 1'b0;
`endif
        end else begin
`ifdef AUD_ARB_TIMEOUT_EN
            rmm_rst_req <= 1'b0;
`endif
            case (state_q)
                StIdle: begin
                    if (handshake) begin
                        gnt_q        <= req1_ready;
                        last_grant_q <= req1_ready;
                        busy         <= 1'b1;
                        if (sel_size == 2'd3) begin
                            state_q <= StResp;
                        end else begin
                            state_q     <= StIssue;
                            write_q     <= sel_write;
                            rmm_addr    <= sel_addr;
                            rmm_wdata   <= sel_wdata;
                            rmm_size    <= sel_size;
                            rmm_we      <= sel_write;
                            rmm_re      <= ~sel_write;
                            rmm_data_oe <= sel_write;
                            cmd_cnt_q   <= 4'd1;
                        end
                    end
                end
                StIssue: begin
                    // Strobe has been high cmd_cnt_q cycles; drop it after the last one.
                    if (cmd_cnt_q == CmdLast) begin
                        rmm_we  <= 1'b0;
                        rmm_re  <= 1'b0;
                        state_q <= StWait;
`ifdef AUD_ARB_TIMEOUT_EN
                        wait_cnt_q <= '0;
`endif
                    end else begin
                        cmd_cnt_q <= cmd_cnt_q + 4'd1;
                    end
                end
                StWait: begin
                    if (rsp_set) begin
                        state_q     <= StResp;
                        rmm_data_oe <= 1'b0;
                    end
`ifdef AUD_ARB_TIMEOUT_EN
                    else if (wait_cnt_q == TimeoutLast) begin
                        rmm_rst_req  <= 1'b1;
                        timeout_seen <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                    end
`endif
                end
                StResp: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_aud_rmm_arb.sv
// Testbench for aud_rmm_arb: directed transaction table, reset-in-WAIT sequence and
// randomized transactions checked against a transaction-level model.
module tb_aud_rmm_arb;

    localparam int unsigned CMD = 3;

    logic        aud_ck = 1'b0;
    logic        rst    = 1'b1;
    logic        req0_valid = 0, req0_write = 0, req1_valid = 0, req1_write = 0;
    logic [31:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
    logic [1:0]  req0_size = 0, req1_size = 0;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic [31:0] rmm_addr, rmm_wdata;
    logic [31:0] rmm_rdata = 0;
    logic        rmm_data_oe, rmm_we, rmm_re, rmm_rst_req, busy;
    logic [1:0]  rmm_size;
    logic        rmm_done = 0, rmm_err = 0;
`ifdef AUD_ARB_TIMEOUT_EN
    logic        timeout_seen;
`endif

    aud_rmm_arb #(.CMD_CYCLES(CMD), .TIMEOUT_CYCLES(1024)) dut (
        .aud_ck(aud_ck), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_size(req0_size),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_size(req1_size),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .rmm_addr(rmm_addr), .rmm_wdata(rmm_wdata), .rmm_data_oe(rmm_data_oe),
        .rmm_rdata(rmm_rdata), .rmm_size(rmm_size), .rmm_we(rmm_we), .rmm_re(rmm_re),
        .rmm_done(rmm_done), .rmm_err(rmm_err), .rmm_rst_req(rmm_rst_req),
`ifdef AUD_ARB_TIMEOUT_EN
        .timeout_seen(timeout_seen),
`endif
        .busy(busy)
    );

    always #5 aud_ck = ~aud_ck;

    int          n_vec = 0;
    int          n_err = 0;
    bit          lg;          // model: last granted port
    logic [31:0] hold_rd[2];  // model: rdata each port should be holding

    typedef struct {
        bit          v0, v1, wr;
        logic [1:0]  sz;
        logic [31:0] addr, wdata, rd;
        int          dly;
        bit          mdone, merr, keep;
        int          eg;
        bit          ee;
        logic [31:0] erd;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic rv(input int p);
        return (p == 1) ? rsp1_valid : rsp0_valid;
    endfunction

    function automatic logic re_(input int p);
        return (p == 1) ? rsp1_err : rsp0_err;
    endfunction

    function automatic logic [31:0] rd_(input int p);
        return (p == 1) ? rsp1_rdata : rsp0_rdata;
    endfunction

    // One transaction from presentation in IDLE to the first IDLE cycle afterwards.
    // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT in IDLE.
    task automatic run_txn(input vec_t v);
        bit found;
        req0_valid = v.v0; req1_valid = v.v1;
        req0_write = v.wr; req1_write = v.wr;
        req0_addr = v.addr; req1_addr = v.addr;
        req0_wdata = v.wdata; req1_wdata = v.wdata;
        req0_size = v.sz; req1_size = v.sz;
        #1;
        chk("ready0", req0_ready, (v.eg == 0));
        chk("ready1", req1_ready, (v.eg == 1));
        @(negedge aud_ck);
        if (!v.keep) begin
            req0_valid = 0;
            req1_valid = 0;
        end
        if (v.sz == 2'd3) begin
            found = 0;
            for (int i = 0; i < 2 && !found; i++) begin
                chk("illegal_no_cmd", {rmm_we, rmm_re}, 0);
                if (rv(v.eg)) found = 1;
                else @(negedge aud_ck);
            end
            chk("illegal_rsp_seen", found, 1);
        end else begin
            for (int i = 0; i < int'(CMD); i++) begin
                chk("issue_we", rmm_we, v.wr);
                chk("issue_re", rmm_re, !v.wr);
                chk("issue_oe", rmm_data_oe, v.wr);
                chk("issue_addr", rmm_addr, v.addr);
                chk("issue_size", rmm_size, v.sz);
                if (v.wr) chk("issue_wdata", rmm_wdata, v.wdata);
                chk("issue_busy", busy, 1);
                chk("issue_ready", {req0_ready, req1_ready}, 0);
                @(negedge aud_ck);
            end
            chk("wait_strobe", {rmm_we, rmm_re}, 0);
            chk("wait_oe", rmm_data_oe, v.wr);
            chk("wait_addr", rmm_addr, v.addr);
            for (int k = 0; k < v.dly; k++) begin
                chk("wait_no_rsp", {rsp0_valid, rsp1_valid}, 0);
                @(negedge aud_ck);
            end
            rmm_done = v.mdone; rmm_err = v.merr; rmm_rdata = v.rd;
            @(negedge aud_ck);
            rmm_done = 0; rmm_err = 0;
        end
        // RESP cycle
        chk("rsp_valid", rv(v.eg), 1);
        chk("rsp_other_quiet", rv(1 - v.eg), 0);
        chk("rsp_err", re_(v.eg), v.ee);
        chk("rsp_rdata", rd_(v.eg), v.erd);
        chk("rsp_other_hold", rd_(1 - v.eg), hold_rd[1 - v.eg]);
        chk("resp_oe", {rmm_data_oe, rmm_we, rmm_re}, 0);
        chk("rst_req_idle", rmm_rst_req, 0);
        hold_rd[v.eg] = v.erd;
        lg = v.eg[0];
        @(negedge aud_ck);
        chk("after_rsp_quiet", {rsp0_valid, rsp1_valid}, 0);
        chk("after_rsp_busy", busy, 0);
    endtask

    initial begin
        vec_t r;
        int   pick;
        tbl[0]  = '{1, 0, 1, 2'd2, 32'h01234567, 32'h89ABCDEF, 32'h0,        2, 1, 0, 0, 0, 0, 32'h0};
        tbl[1]  = '{0, 1, 0, 2'd2, 32'h01234567, 32'h0,        32'h76543210, 1, 1, 0, 0, 1, 0, 32'h76543210};
        tbl[2]  = '{1, 1, 1, 2'd1, 32'h00000100, 32'h00000011, 32'h0,        0, 1, 0, 1, 0, 0, 32'h0};
        tbl[3]  = '{1, 1, 0, 2'd0, 32'h00000104, 32'h0,        32'h000000AA, 3, 1, 0, 1, 1, 0, 32'h000000AA};
        tbl[4]  = '{1, 1, 0, 2'd2, 32'h00000108, 32'h0,        32'h000000BB, 1, 1, 0, 1, 0, 0, 32'h000000BB};
        tbl[5]  = '{1, 1, 1, 2'd2, 32'h0000010C, 32'h55AA55AA, 32'h0,        0, 1, 0, 0, 1, 0, 32'h0};
        tbl[6]  = '{1, 0, 1, 2'd3, 32'h00000200, 32'h12345678, 32'h0,        0, 0, 0, 0, 0, 1, 32'h0};
        tbl[7]  = '{1, 0, 0, 2'd1, 32'h00000204, 32'h0,        32'h00001234, 0, 1, 1, 0, 0, 1, 32'h00001234};
        tbl[8]  = '{1, 1, 0, 2'd0, 32'h00000208, 32'h0,        32'h00005678, 2, 0, 1, 0, 1, 1, 32'h00005678};
        tbl[9]  = '{0, 1, 1, 2'd0, 32'h0000020C, 32'hDEADBEEF, 32'h0,        1, 1, 0, 0, 1, 0, 32'h0};
        tbl[10] = '{1, 1, 0, 2'd2, 32'h00000210, 32'h0,        32'hCAFEF00D, 0, 1, 0, 0, 0, 0, 32'hCAFEF00D};

        lg = 1;
        hold_rd[0] = 0;
        hold_rd[1] = 0;
        repeat (3) @(negedge aud_ck);
        chk("reset_busy", busy, 0);
        chk("reset_cmd", {rmm_we, rmm_re, rmm_data_oe, rmm_rst_req}, 0);
        chk("reset_rsp", {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}, 0);
        chk("reset_addr", rmm_addr, 0);
        rst = 0;
        @(negedge aud_ck);

        for (int i = 0; i < 11; i++) run_txn(tbl[i]);

        // Reset asserted asynchronously mid-WAIT with both ports requesting.
        req0_valid = 1; req0_write = 1; req0_size = 2'd2;
        req0_addr = 32'h0000_0300; req0_wdata = 32'hFFFF_0000;
        @(negedge aud_ck);
        req0_valid = 0;
        repeat (CMD) @(negedge aud_ck);
        chk("pre_reset_wait_busy", busy, 1);
        req0_valid = 1; req1_valid = 1;
        #2 rst = 1;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_cmd", {rmm_we, rmm_re, rmm_data_oe, rmm_rst_req}, 0);
        chk("async_rst_addr", rmm_addr, 0);
        chk("async_rst_wdata", rmm_wdata, 0);
        chk("async_rst_rdata0", rsp0_rdata, 0);
        chk("async_rst_rdata1", rsp1_rdata, 0);
        chk("async_rst_ready", {req0_ready, req1_ready}, 0);
        @(negedge aud_ck);
        rst = 0;
        lg = 1;
        hold_rd[0] = 0;
        hold_rd[1] = 0;
        r = '{1, 1, 0, 2'd2, 32'h00000400, 32'h0, 32'h13579BDF, 0, 1, 0, 0, 0, 0, 32'h13579BDF};
        run_txn(r);

        // Randomized transactions against the model.
        for (int n = 0; n < 40; n++) begin
            pick    = $urandom_range(1, 3);
            r.v0    = pick[0];
            r.v1    = pick[1];
            r.wr    = 1'($urandom_range(0, 1));
            r.sz    = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r.addr  = $urandom;
            r.wdata = $urandom;
            r.rd    = $urandom;
            r.dly   = $urandom_range(0, 4);
            pick    = $urandom_range(1, 3);
            r.mdone = pick[0];
            r.merr  = pick[1];
            r.keep  = 0;
            if (r.v0 && r.v1) r.eg = lg ? 0 : 1;
            else r.eg = r.v0 ? 0 : 1;
            r.ee  = (r.sz == 2'd3) || r.merr;
            r.erd = (r.sz == 2'd3 || r.wr) ? 32'h0 : r.rd;
            run_txn(r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

endmodule
